// File: rtl/test_run_sequencer_if.sv
// Run/stall-rate link between the test-run sequencer and the compiled test runner.
//   run_valid / run_rdy      : run request handshake (sequencer -> runner)
//   run_empty / run_rden     : result FIFO status and pop strobe
//   rst_and_startup_done     : runner has finished reset/startup
//   stall_rate_supported     : runner accepts stall-rate programming
//   stall_rate_valid / _rate : one-cycle stall-rate write
// master = sequencer side, slave = runner side.
interface test_run_sequencer_if #(
  parameter int unsigned StallRateW = 3
) ();
  logic                  run_valid;
  logic                  run_rdy;
  logic                  run_empty;
  logic                  run_rden;
  logic                  rst_and_startup_done;
  logic                  stall_rate_supported;
  logic                  stall_rate_valid;
  logic [StallRateW-1:0] stall_rate;

  modport master (
    output run_valid,
    output run_rden,
    output stall_rate_valid,
    output stall_rate,
    input  run_rdy,
    input  run_empty,
    input  rst_and_startup_done,
    input  stall_rate_supported
  );

  modport slave (
    input  run_valid,
    input  run_rden,
    input  stall_rate_valid,
    input  stall_rate,
    output run_rdy,
    output run_empty,
    output rst_and_startup_done,
    output stall_rate_supported
  );
endinterface

// File: rtl/test_run_sequencer.sv
// Synthesizable driver for the test-runner run interface. After start_i it waits for the runner
// startup, optionally programs a stall rate, then issues NumRuns run requests, popping one result
// after each, and reports pass / timeout / fault together with run and cycle counts.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   start_i         : one-cycle start pulse (ignored while busy)
//   run_if          : runner link (master side)
//   busy_o, done_o  : sequence in progress / finished (sticky until next start)
//   pass_o          : all runs drained (valid with done_o)
//   timeout_o       : cycle budget exhausted (valid with done_o)
//   runs_done_o     : results drained so far
//   cycle_count_o   : cycles spent outside idle/done, saturating
module test_run_sequencer #(
  parameter int unsigned NumRuns       = 1,
  parameter int unsigned TimeoutCycles = 1000000,
  parameter int unsigned CntW          = 32,
  parameter int unsigned StallRateW    = 3,
  parameter int unsigned StallRate     = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  test_run_sequencer_if.master  run_if,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [CntW-1:0]       runs_done_o,
  output logic [CntW-1:0]       cycle_count_o
);

  localparam logic [CntW-1:0]       NumRunsC   = CntW'(NumRuns);
  localparam logic [CntW-1:0]       TimeoutC   = CntW'(TimeoutCycles);
  localparam logic [StallRateW-1:0] StallRateC = StallRateW'(StallRate);
  localparam bit                    DoCfg      = (StallRate != 0);
  localparam bit                    ZeroRuns   = (NumRuns == 0);

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StCfg,
    StIssue,
    StWaitRes,
    StDrain,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  rden_q, rden_d;
  logic                  stall_valid_q, stall_valid_d;
  logic [StallRateW-1:0] stall_rate_q, stall_rate_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [CntW-1:0]       runs_q, runs_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  in_busy;
  logic                  timeout_hit;
  logic                  fault;
  logic [CntW-1:0]       cnt_inc;
  logic [CntW-1:0]       runs_inc;

  assign in_busy  = (state_q != StIdle) && (state_q != StDone);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
  assign runs_inc = runs_q + CntW'(1);
  // Budget is judged on the count this cycle will leave behind, so done lands exactly at the limit.
  assign timeout_hit = in_busy && (cnt_inc >= TimeoutC);
  // Losing runner startup once past the startup wait is a fault.
  assign fault = in_busy && (state_q != StWaitStart) && !run_if.rst_and_startup_done;

  always_comb begin
    state_d       = state_q;
    valid_d       = 1'b0;
    rden_d        = 1'b0;
    stall_valid_d = 1'b0;
    stall_rate_d  = stall_rate_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    runs_d        = runs_q;
    cnt_d         = in_busy ? cnt_inc : cnt_q;

    if (timeout_hit) begin
      state_d   = StDone;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      pass_d    = 1'b0;
      timeout_d = 1'b1;
    end else if (fault) begin
      state_d   = StDone;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_d   = StWaitStart;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            runs_d    = '0;
            cnt_d     = '0;
          end
        end
        StWaitStart: begin
          if (run_if.rst_and_startup_done) begin
            if (DoCfg && run_if.stall_rate_supported) begin
              state_d       = StCfg;
              stall_valid_d = 1'b1;
              stall_rate_d  = StallRateC;
            end else if (ZeroRuns) begin
              state_d = StDone;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end else begin
              state_d = StIssue;
              valid_d = 1'b1;
            end
          end
        end
        StCfg: begin
          if (ZeroRuns) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = StIssue;
            valid_d = 1'b1;
          end
        end
        StIssue: begin
          if (run_if.run_rdy) begin
            state_d = StWaitRes;
          end else begin
            valid_d = 1'b1;
          end
        end
        StWaitRes: begin
          if (!run_if.run_empty) begin
            state_d = StDrain;
            rden_d  = 1'b1;
          end
        end
        StDrain: begin
          runs_d = runs_inc;
          if (runs_inc == NumRunsC) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = StIssue;
            valid_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      valid_q       <= 1'b0;
      rden_q        <= 1'b0;
      stall_valid_q <= 1'b0;
      stall_rate_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      runs_q        <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      rden_q        <= rden_d;
      stall_valid_q <= stall_valid_d;
      stall_rate_q  <= stall_rate_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      runs_q        <= runs_d;
      cnt_q         <= cnt_d;
    end
  end

  assign run_if.run_valid        = valid_q;
  assign run_if.run_rden         = rden_q;
  assign run_if.stall_rate_valid = stall_valid_q;
  assign run_if.stall_rate       = stall_rate_q;
  assign busy_o                  = busy_q;
  assign done_o                  = done_q;
  assign pass_o                  = pass_q;
  assign timeout_o               = timeout_q;
  assign runs_done_o             = runs_q;
  assign cycle_count_o           = cnt_q;

endmodule

// File: tb/tb_test_run_sequencer.sv
// Bench for test_run_sequencer. Three instances:
//   A: 4 runs, stall rate 5, generous timeout, driven by a randomized runner model
//   B: 1 run, timeout 50, directed stimulus
//   C: 0 runs
module tb_test_run_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  test_run_sequencer_if #(.StallRateW(3)) a_if ();
  test_run_sequencer_if #(.StallRateW(3)) b_if ();
  test_run_sequencer_if #(.StallRateW(3)) c_if ();

  logic        a_start, b_start, c_start;
  logic        a_busy, a_done, a_pass, a_tmo;
  logic        b_busy, b_done, b_pass, b_tmo;
  logic        c_busy, c_done, c_pass, c_tmo;
  logic [31:0] a_runs, a_cnt, b_runs, b_cnt, c_runs, c_cnt;

  test_run_sequencer #(
    .NumRuns(4), .TimeoutCycles(3000), .CntW(32), .StallRateW(3), .StallRate(5)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(a_start), .run_if(a_if.master),
    .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .timeout_o(a_tmo),
    .runs_done_o(a_runs), .cycle_count_o(a_cnt)
  );

  test_run_sequencer #(
    .NumRuns(1), .TimeoutCycles(50), .CntW(32), .StallRateW(3), .StallRate(0)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(b_start), .run_if(b_if.master),
    .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .timeout_o(b_tmo),
    .runs_done_o(b_runs), .cycle_count_o(b_cnt)
  );

  test_run_sequencer #(
    .NumRuns(0), .TimeoutCycles(100), .CntW(32), .StallRateW(3), .StallRate(0)
  ) u_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(c_start), .run_if(c_if.master),
    .busy_o(c_busy), .done_o(c_done), .pass_o(c_pass), .timeout_o(c_tmo),
    .runs_done_o(c_runs), .cycle_count_o(c_cnt)
  );

  // Runner model for A: one outstanding request at most, result appears after a random latency,
  // each result must be popped exactly once. Sampled on the falling edge so the values seen are
  // the ones the DUT will act on at the next rising edge.
  int a_lat_min = 0, a_lat_max = 20;
  logic a_flush = 1'b0;
  int a_hs = 0, a_pop = 0, a_order_err = 0, a_valid_seen = 0;
  int a_stall_pulses = 0, a_stall_bad = 0, a_stall_valid_at = -1;
  int a_out = 0, a_fifo = 0, a_lat = 0;
  bit a_pend = 1'b0;

  always @(negedge clk) begin
    if (!rst_n || a_flush) begin
      a_out  = 0;
      a_fifo = 0;
      a_pend = 1'b0;
      a_if.run_empty = 1'b1;
    end else begin
      if (a_if.run_valid) a_valid_seen++;
      if (a_if.stall_rate_valid) begin
        a_stall_pulses++;
        a_stall_valid_at = a_valid_seen;
        if (a_if.stall_rate !== 3'd5) a_stall_bad++;
      end
      if (a_if.run_valid && a_if.run_rdy) begin
        a_hs++;
        if (a_out != 0) a_order_err++;
        a_out  = 1;
        a_pend = 1'b1;
        a_lat  = int'($urandom_range(a_lat_max, a_lat_min));
      end else if (a_pend) begin
        if (a_lat == 0) begin
          a_fifo++;
          a_pend = 1'b0;
        end else begin
          a_lat--;
        end
      end
      if (a_if.run_rden) begin
        a_pop++;
        if (a_out != 1 || a_fifo == 0) begin
          a_order_err++;
        end else begin
          a_fifo--;
          a_out = 0;
        end
      end
      a_if.run_empty = (a_fifo == 0);
    end
  end

  int b_hs = 0, b_pop = 0, c_valid = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_if.run_valid && b_if.run_rdy) b_hs++;
      if (b_if.run_rden) b_pop++;
      if (c_if.run_valid) c_valid++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int s, d, hs0, pop0, vs0, st0;

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_if.run_rdy = 1'b1; a_if.rst_and_startup_done = 1'b0; a_if.stall_rate_supported = 1'b1;
    b_if.run_rdy = 1'b1; b_if.rst_and_startup_done = 1'b0; b_if.stall_rate_supported = 1'b1;
    b_if.run_empty = 1'b1;
    c_if.run_rdy = 1'b1; c_if.rst_and_startup_done = 1'b1; c_if.stall_rate_supported = 1'b1;
    c_if.run_empty = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_valid", a_if.run_valid, 0);
    chk("rst_rden", a_if.run_rden, 0);
    chk("rst_stall_rate", a_if.stall_rate, 0);
    chk("rst_cnt", a_cnt, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: single run, startup 5 cycles after start, result 3 cycles after handshake
    hs0 = b_hs; pop0 = b_pop;
    b_start = 1'b1; tick(); b_start = 1'b0; s = int'(cyc);
    chk("t1_busy_after_start", b_busy, 1);
    chk("t1_done_after_start", b_done, 0);
    repeat (4) tick();
    b_if.rst_and_startup_done = 1'b1;
    for (int i = 0; i < 20 && b_hs == hs0; i++) tick();
    chk("t1_handshake", b_hs - hs0, 1);
    chk("t1_valid_drop", b_if.run_valid, 0);
    repeat (3) tick();
    b_if.run_empty = 1'b0;
    for (int i = 0; i < 20 && b_pop == pop0; i++) tick();
    b_if.run_empty = 1'b1;
    for (int i = 0; i < 20 && b_done !== 1'b1; i++) tick();
    d = int'(cyc);
    chk("t1_done", b_done, 1);
    chk("t1_pass", b_pass, 1);
    chk("t1_timeout", b_tmo, 0);
    chk("t1_runs", b_runs, 1);
    chk("t1_pops", b_pop - pop0, 1);
    chk("t1_hs_total", b_hs - hs0, 1);
    chk("t1_cycles", b_cnt, d - s);
    chk("t1_busy_end", b_busy, 0);

    // 4: result never arrives -> timeout at exactly 50 cycles
    hs0 = b_hs; pop0 = b_pop;
    b_start = 1'b1; tick(); b_start = 1'b0; s = int'(cyc);
    chk("t4_restart_runs", b_runs, 0);
    for (int i = 0; i < 200 && b_done !== 1'b1; i++) tick();
    d = int'(cyc);
    chk("t4_done", b_done, 1);
    chk("t4_timeout", b_tmo, 1);
    chk("t4_pass", b_pass, 0);
    chk("t4_cnt", b_cnt, 50);
    chk("t4_latency", d - s, 50);
    chk("t4_no_rden", b_pop - pop0, 0);
    chk("t4_one_req", b_hs - hs0, 1);
    chk("t4_runs", b_runs, 0);
    tick();
    chk("t4_cnt_held", b_cnt, 50);

    // Zero runs: done with pass right after startup
    c_start = 1'b1; tick(); c_start = 1'b0; s = int'(cyc);
    for (int i = 0; i < 20 && c_done !== 1'b1; i++) tick();
    d = int'(cyc);
    chk("t0_done", c_done, 1);
    chk("t0_pass", c_pass, 1);
    chk("t0_no_valid", c_valid, 0);
    chk("t0_cnt", c_cnt, d - s);
    chk("t0_runs", c_runs, 0);

    // 3 + 5: four runs with random latency, stall programming, a start pulse mid-run
    hs0 = a_hs; pop0 = a_pop; vs0 = a_valid_seen; st0 = a_stall_pulses;
    a_if.rst_and_startup_done = 1'b1;
    a_start = 1'b1; tick(); a_start = 1'b0; s = int'(cyc);
    for (int i = 0; i < 200 && (a_hs - hs0) < 2; i++) tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < 1000 && a_done !== 1'b1; i++) tick();
    d = int'(cyc);
    chk("t3_done", a_done, 1);
    chk("t3_pass", a_pass, 1);
    chk("t3_timeout", a_tmo, 0);
    chk("t3_runs", a_runs, 4);
    chk("t3_handshakes", a_hs - hs0, 4);
    chk("t3_pops", a_pop - pop0, 4);
    chk("t3_order", a_order_err, 0);
    chk("t3_cycles", a_cnt, d - s);
    chk("t5_stall_pulses", a_stall_pulses - st0, 1);
    chk("t5_stall_value", a_stall_bad, 0);
    chk("t5_stall_before_valid", a_stall_valid_at, vs0);

    // 2 + 5b: rdy held low, no stall support
    a_lat_min = 2; a_lat_max = 2;
    a_if.run_rdy = 1'b0; a_if.stall_rate_supported = 1'b0;
    hs0 = a_hs; st0 = a_stall_pulses;
    a_start = 1'b1; tick(); a_start = 1'b0; s = int'(cyc);
    for (int i = 0; i < 20 && a_if.run_valid !== 1'b1; i++) tick();
    chk("t2_valid_up", a_if.run_valid, 1);
    for (int i = 0; i < 7; i++) begin
      chk("t2_valid_held", a_if.run_valid, 1);
      tick();
    end
    chk("t2_no_hs_yet", a_hs - hs0, 0);
    a_if.run_rdy = 1'b1;
    tick();
    chk("t2_valid_drop", a_if.run_valid, 0);
    chk("t2_one_hs", a_hs - hs0, 1);
    for (int i = 0; i < 1000 && a_done !== 1'b1; i++) tick();
    d = int'(cyc);
    chk("t2_pass", a_pass, 1);
    chk("t2_order", a_order_err, 0);
    chk("t2_cycles", a_cnt, d - s);
    chk("t5_no_stall", a_stall_pulses - st0, 0);

    // 6a: asynchronous reset while waiting for a result
    a_lat_min = 15; a_lat_max = 15;
    hs0 = a_hs;
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < 20 && a_hs == hs0; i++) tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_valid", a_if.run_valid, 0);
    chk("t6_rst_cnt", a_cnt, 0);
    chk("t6_rst_pass_b", b_pass, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 6b: startup lost mid-run -> fault
    hs0 = a_hs;
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < 20 && a_hs == hs0; i++) tick();
    a_if.rst_and_startup_done = 1'b0;
    for (int i = 0; i < 10 && a_done !== 1'b1; i++) tick();
    chk("t6_fault_done", a_done, 1);
    chk("t6_fault_pass", a_pass, 0);
    chk("t6_fault_timeout", a_tmo, 0);
    a_flush = 1'b1; tick(); a_flush = 1'b0;

    // 6c: restart after done clears everything and completes
    a_lat_min = 0; a_lat_max = 20;
    a_if.rst_and_startup_done = 1'b1;
    hs0 = a_hs; pop0 = a_pop;
    a_start = 1'b1; tick(); a_start = 1'b0; s = int'(cyc);
    chk("t6_restart_runs", a_runs, 0);
    chk("t6_restart_cnt", a_cnt, 0);
    chk("t6_restart_done", a_done, 0);
    chk("t6_restart_busy", a_busy, 1);
    for (int i = 0; i < 1000 && a_done !== 1'b1; i++) tick();
    d = int'(cyc);
    chk("t6_restart_pass", a_pass, 1);
    chk("t6_restart_runs_end", a_runs, 4);
    chk("t6_restart_pops", a_pop - pop0, 4);
    chk("t6_restart_cycles", a_cnt, d - s);
    chk("t6_order", a_order_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
